// File: rtl/pipeline_rr_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter
// and the shared three-stage pipeline chain.
interface pipeline_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
    logic                      en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_stall;
    logic                      pipe_valid;
    logic [DATA_W-1:0]         pipe_data;
    logic                      pipe_stall;
    logic                      pipe_ret_valid;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [ID_W-1:0]           grant_id;
    logic [CNT_W-1:0]          inflight;
    logic                      idle;
    logic                      ret_err;

    // Arbiter side: takes requests and pipeline feedback.
    modport slave (
        input  en, req_valid, req_data, pipe_stall, pipe_ret_valid,
        output req_stall, pipe_valid, pipe_data, rsp_valid,
        output rsp_id, grant_id, inflight, idle, ret_err
    );

    // Environment side: requesters plus the pipeline chain.
    modport master (
        output en, req_valid, req_data, pipe_stall, pipe_ret_valid,
        input  req_stall, pipe_valid, pipe_data, rsp_valid,
        input  rsp_id, grant_id, inflight, idle, ret_err
    );
endinterface

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin front end for a shared in-order pipeline; an ID FIFO
// routes each returning result back to the requester that issued it.
module pipeline_rr_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_rr_arbiter_if.slave  bus
);
    logic              slot_valid;
    logic [DATA_W-1:0] slot_data;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   ptr;

    logic [ID_W-1:0]   id_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic              full;
    logic              can_issue;
    logic              transfer;
    logic              pop;
    logic              empty_ret;

    // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = (int'(ptr) + j) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Issue gating; a full FIFO blocks issue even when a pop is due,
    // and reset holds every requester off.
    always_comb begin
        full      = (count == CNT_W'(FIFO_DEPTH));
        can_issue = rst && bus.en && !full &&
                    (!slot_valid || !bus.pipe_stall);
        transfer  = can_issue && found;
        pop       = bus.pipe_ret_valid && (count != '0);
        empty_ret = bus.pipe_ret_valid && (count == '0);
    end

    // Per-requester stall and one-hot return routing.
    always_comb begin
        bus.req_stall = '1;
        bus.rsp_valid = '0;
        if (transfer) begin
            bus.req_stall[winner] = 1'b0;
        end
        if (pop) begin
            bus.rsp_valid[id_mem[rd_ptr]] = 1'b1;
        end
    end

    // Issue slot toward stage1; holds everything while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            last_grant <= '0;
            ptr        <= '0;
        end else if (transfer) begin
            slot_valid <= 1'b1;
            slot_data  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
            last_grant <= winner;
            if (winner == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= winner + ID_W'(1);
            end
        end else if (!slot_valid || !bus.pipe_stall) begin
            slot_valid <= 1'b0;
        end
    end

    // ID FIFO storage; entry written at the tail on every issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                id_mem[i] <= '0;
            end
        end else if (transfer) begin
            id_mem[wr_ptr] <= winner;
        end
    end

    // FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (transfer) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (transfer && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!transfer && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Sticky flag for a return that had no matching issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ret_err <= 1'b0;
        end else if (empty_ret) begin
            bus.ret_err <= 1'b1;
        end
    end

    assign bus.pipe_valid = slot_valid;
    assign bus.pipe_data  = slot_data;
    assign bus.grant_id   = last_grant;
    assign bus.rsp_id     = id_mem[rd_ptr];
    assign bus.inflight   = count;
    assign bus.idle       = !slot_valid && (count == '0);

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed bench for pipeline_rr_arbiter; returned IDs are checked
// against a scoreboard queue filled as requests are issued.
module tb_pipeline_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int FD = 4;

    logic clk;
    logic rst;

    int tests  = 0;
    int failed = 0;

    logic [DW-1:0] din [NR];
    int            id_q [$];

    pipeline_rr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .FIFO_DEPTH(FD)) bus ();

    pipeline_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i*DW +: DW] = din[i];
        end
    endtask

    // One clock: check stall pattern and returns at negedge, push the
    // expected grant, then check the issue slot just after the edge.
    task automatic cyc(input logic [NR-1:0] exp_stall, input int exp_k);
        logic [DW-1:0] exp_data;
        logic [NR-1:0] oh;
        int            e;
        exp_data = '0;
        @(negedge clk);
        chk("req_stall", bus.req_stall, exp_stall);
        if (bus.pipe_ret_valid) begin
            if (id_q.size() > 0) begin
                e = id_q.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                chk("rsp_id", bus.rsp_id, e);
                chk("rsp_valid", bus.rsp_valid, oh);
            end else begin
                chk("rsp_valid_empty", bus.rsp_valid, 0);
            end
        end else begin
            chk("rsp_valid_idle", bus.rsp_valid, 0);
        end
        if (exp_k >= 0) begin
            id_q.push_back(exp_k);
            exp_data = din[exp_k];
        end
        @(posedge clk);
        #1;
        if (exp_k >= 0) begin
            chk("pipe_valid", bus.pipe_valid, 1);
            chk("pipe_data", bus.pipe_data, exp_data);
            chk("grant_id", bus.grant_id, exp_k);
        end
    endtask

    initial begin
        rst                = 1'b0;
        bus.en             = 1'b1;
        bus.req_valid      = 4'hF;
        bus.req_data       = '0;
        bus.pipe_stall     = 1'b0;
        bus.pipe_ret_valid = 1'b0;
        for (int i = 0; i < NR; i++) din[i] = 32'hA0 + i;

        // reset state with requests pending
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pipe_valid", bus.pipe_valid, 0);
        chk("rst_pipe_data", bus.pipe_data, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_ret_err", bus.ret_err, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_req_stall", bus.req_stall, 4'hF);

        // single requester 2 fills the FIFO
        rst = 1'b1;
        bus.req_valid = 4'b0100;
        for (int n = 0; n < FD; n++) begin
            din[2] = 32'h10 + n;
            drive_data();
            cyc(4'b1011, 2);
        end
        chk("full_inflight", bus.inflight, FD);
        #2;
        chk("full_stall", bus.req_stall, 4'hF);

        // mid-traffic reset discards everything
        rst = 1'b0;
        #1;
        chk("mid_rst_pipe_valid", bus.pipe_valid, 0);
        chk("mid_rst_inflight", bus.inflight, 0);
        chk("mid_rst_idle", bus.idle, 1);
        chk("mid_rst_ret_err", bus.ret_err, 0);
        chk("mid_rst_stall", bus.req_stall, 4'hF);
        id_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // all requesting, returns every cycle: order 0,1,2,3,0,1
        for (int i = 0; i < NR; i++) din[i] = 32'hA0 + i;
        drive_data();
        bus.req_valid = 4'hF;
        cyc(4'b1110, 0);
        bus.pipe_ret_valid = 1'b1;
        cyc(4'b1101, 1);
        cyc(4'b1011, 2);
        cyc(4'b0111, 3);
        cyc(4'b1110, 0);
        cyc(4'b1101, 1);
        chk("rr_inflight", bus.inflight, 1);
        bus.req_valid = 4'b0000;
        cyc(4'b1111, -1);
        bus.pipe_ret_valid = 1'b0;
        chk("rr_drained", bus.inflight, 0);

        // downstream stall freezes the slot and the pointer
        bus.req_valid = 4'b1001;
        cyc(4'b0111, 3);
        bus.pipe_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc(4'b1111, -1);
            chk("stall_valid", bus.pipe_valid, 1);
            chk("stall_data", bus.pipe_data, 32'hA3);
            chk("stall_grant", bus.grant_id, 3);
        end
        bus.pipe_stall = 1'b0;
        cyc(4'b1110, 0);
        bus.req_valid = 4'b0000;
        cyc(4'b1111, -1);
        chk("slot_free_valid", bus.pipe_valid, 0);
        chk("slot_free_data", bus.pipe_data, 32'hA0);
        bus.pipe_ret_valid = 1'b1;
        cyc(4'b1111, -1);
        cyc(4'b1111, -1);
        bus.pipe_ret_valid = 1'b0;

        // fill with IDs 1,3,0,2 then one return reopens issue
        bus.req_valid = 4'b0010;
        cyc(4'b1101, 1);
        bus.req_valid = 4'b1000;
        cyc(4'b0111, 3);
        bus.req_valid = 4'b0001;
        cyc(4'b1110, 0);
        bus.req_valid = 4'b0100;
        cyc(4'b1011, 2);
        bus.req_valid = 4'hF;
        cyc(4'b1111, -1);
        chk("fill_inflight", bus.inflight, 4);
        bus.pipe_ret_valid = 1'b1;
        cyc(4'b1111, -1);
        bus.pipe_ret_valid = 1'b0;
        chk("pop_inflight", bus.inflight, 3);
        cyc(4'b0111, 3);
        chk("refill_inflight", bus.inflight, 4);

        // en=0 drains without issuing
        bus.en = 1'b0;
        bus.pipe_ret_valid = 1'b1;
        for (int n = 0; n < 3; n++) cyc(4'b1111, -1);
        chk("drain_not_idle", bus.idle, 0);
        cyc(4'b1111, -1);
        chk("drain_idle", bus.idle, 1);
        chk("drain_inflight", bus.inflight, 0);
        chk("drain_ret_err", bus.ret_err, 0);

        // return with empty FIFO sets sticky error
        cyc(4'b1111, -1);
        chk("empty_ret_err", bus.ret_err, 1);
        chk("empty_inflight", bus.inflight, 0);
        bus.pipe_ret_valid = 1'b0;
        bus.en = 1'b1;
        bus.req_valid = 4'b0000;
        cyc(4'b1111, -1);
        chk("sticky_ret_err", bus.ret_err, 1);
        chk("end_queue_empty", id_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
